// File: rtl/keypad_scanner.sv
// keypad_scanner
// Scans a 4x4 active-low matrix keypad, debounces presses and releases over
// whole scans, and emits one clean key event per physical press.
//
// Parameters
//   SCAN_DIV        clock cycles each row is driven (>= 4)
//   DEBOUNCE_SCANS  identical complete scans needed to accept a press/release (>= 1)
//   REPEAT_SCANS    complete scans between auto-repeat events
//
// Ports
//   clk      system clock
//   rst      asynchronous active-low reset
//   col[3:0] keypad columns, active-low, pulled up
//   row[3:0] keypad row drive, one-hot active-low
//   key[3:0] code of last accepted key, 4*row_index + col_index
//   flag     one-cycle pulse per accepted key event
//   pressed  high while a key is accepted and held
//
// Build option
//   KEYPAD_AUTOREPEAT_EN  when defined, a held single key re-pulses flag every
//                         REPEAT_SCANS complete scans.
//
// FSM states
//   state      | meaning
//   S_IDLE     | no key accepted, waiting for a single-key scan
//   S_DEBOUNCE | candidate key seen, counting identical single-key scans
//   S_HELD     | key accepted and still down
//   S_RELEASE  | key accepted, counting empty scans before returning to idle

module keypad_scanner #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] key,
    output logic       flag,
    output logic       pressed
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_LIMIT = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || REPEAT_SCANS < 1) begin : g_bad_params
        $error("keypad_scanner: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_HELD,
        S_RELEASE
    } state_t;

    // ------------------------------------------------------------------
    // Column synchroniser
    // ------------------------------------------------------------------
    logic [3:0] col_meta;
    logic [3:0] col_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_meta <= 4'hF;
            col_sync <= 4'hF;
        end else begin
            col_meta <= col;
            col_sync <= col_meta;
        end
    end

    // ------------------------------------------------------------------
    // Row dwell timer, row drive and snapshot capture
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       row_idx;
    logic [15:0]      snapshot;
    logic             scan_valid;
    logic             dwell_end;

    assign dwell_end = (div_cnt == DIV_LAST);
    assign row       = ~(4'b0001 << row_idx);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt    <= '0;
            row_idx    <= 2'd0;
            snapshot   <= 16'h0000;
            scan_valid <= 1'b0;
        end else if (dwell_end) begin
            div_cnt                       <= '0;
            row_idx                       <= row_idx + 2'd1;
            snapshot[{row_idx, 2'b00} +: 4] <= ~col_sync;
            scan_valid                    <= (row_idx == 2'd3);
        end else begin
            div_cnt    <= div_cnt + DIV_W'(1);
            scan_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Scan classification. scan_valid is high the cycle after the row-3
    // sample, when the snapshot holds all four freshly sampled rows; row 0
    // of the next scan is not overwritten until SCAN_DIV-1 cycles later.
    // ------------------------------------------------------------------
    logic [4:0] hit_count;
    logic [3:0] hit_code;
    logic       scan_none;
    logic       scan_single;

    always_comb begin
        hit_count = 5'd0;
        hit_code  = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (snapshot[i]) begin
                hit_count = hit_count + 5'd1;
                hit_code  = 4'(i);
            end
        end
    end

    assign scan_none   = (hit_count == 5'd0);
    assign scan_single = (hit_count == 5'd1);

    // ------------------------------------------------------------------
    // Debounce / hold FSM
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [3:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [3:0]       key_q, key_d;
    logic             flag_q, flag_d;

    // Shared press/release counter, saturating at the debounce limit.
    assign cnt_inc = (cnt_q == DEB_LIMIT) ? cnt_q : cnt_q + CNT_ONE;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REPEAT_SCANS + 1);
    localparam logic [REP_W-1:0] REP_LIMIT = REP_W'(REPEAT_SCANS);
    logic [REP_W-1:0] rep_q, rep_d;
    logic [REP_W-1:0] rep_inc;

    assign rep_inc = rep_q + REP_W'(1);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cand_q  <= 4'd0;
            cnt_q   <= '0;
            key_q   <= 4'd0;
            flag_q  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            flag_q  <= flag_d;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q   <= rep_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        flag_d  = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_d   = rep_q;
`endif
        if (scan_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (scan_single) begin
                        if (DEB_LIMIT == CNT_ONE) begin
                            key_d   = hit_code;
                            flag_d  = 1'b1;
                            cnt_d   = '0;
                            state_d = S_HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                            rep_d   = '0;
`endif
                        end else begin
                            cand_d  = hit_code;
                            cnt_d   = CNT_ONE;
                            state_d = S_DEBOUNCE;
                        end
                    end
                end
                S_DEBOUNCE: begin
                    if (scan_single) begin
                        if (hit_code == cand_q) begin
                            cnt_d = cnt_inc;
                            if (cnt_inc == DEB_LIMIT) begin
                                key_d   = cand_q;
                                flag_d  = 1'b1;
                                cnt_d   = '0;
                                state_d = S_HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                                rep_d   = '0;
`endif
                            end
                        end else begin
                            cand_d = hit_code;
                            cnt_d  = CNT_ONE;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end
                end
                S_HELD: begin
                    if (scan_none) begin
                        // A one-scan debounce releases on the first empty scan.
                        if (DEB_LIMIT == CNT_ONE) begin
                            cnt_d   = '0;
                            state_d = S_IDLE;
                        end else begin
                            cnt_d   = CNT_ONE;
                            state_d = S_RELEASE;
                        end
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_d = '0;
                    end else if (scan_single && hit_code == key_q) begin
                        if (rep_inc == REP_LIMIT) begin
                            flag_d = 1'b1;
                            rep_d  = '0;
                        end else begin
                            rep_d = rep_inc;
                        end
                    end else begin
                        rep_d = '0;
`endif
                    end
                end
                S_RELEASE: begin
                    if (scan_none) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DEB_LIMIT) begin
                            cnt_d   = '0;
                            state_d = S_IDLE;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = S_HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_d   = '0;
`endif
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign key     = key_q;
    assign flag    = flag_q;
    assign pressed = (state_q == S_HELD) || (state_q == S_RELEASE);

endmodule

// File: tb/tb_keypad_scanner.sv
// Testbench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3, REPEAT_SCANS=8.
// A keypad model pulls columns low for pressed keys on the driven row. Each
// complete scan gets one 16-bit key pattern; a scan-level reference model
// predicts flag, key and pressed, which are compared every cycle.

module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;
    localparam int REP      = 8;
    localparam int WIN      = 4 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [3:0]  key;
    logic        flag;
    logic        pressed;
    logic [15:0] keys_down = 16'h0000;

    int checks = 0;
    int errors = 0;
    int flag_total = 0;

    // scan-level reference model
    bit m_held;
    bit m_flag;
    int m_key;
    int m_run_code;
    int m_run_len;
    int m_gap;
    int m_rep;

    keypad_scanner #(
        .SCAN_DIV      (SCAN_DIV),
        .DEBOUNCE_SCANS(DEB),
        .REPEAT_SCANS  (REP)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .col    (col),
        .row    (row),
        .key    (key),
        .flag   (flag),
        .pressed(pressed)
    );

    always #5 clk = ~clk;

    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!row[r]) begin
                for (int c = 0; c < 4; c++) begin
                    if (keys_down[4*r+c]) col[c] = 1'b0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_held = 0; m_flag = 0; m_key = 0;
        m_run_code = 0; m_run_len = 0; m_gap = 0; m_rep = 0;
    endtask

    task automatic model_scan(input logic [15:0] p);
        int n;
        int code;
        n = $countones(p);
        code = 0;
        for (int i = 0; i < 16; i++) if (p[i]) code = i;
        m_flag = 0;
        if (!m_held) begin
            if (n == 1) begin
                if (m_run_len > 0 && code == m_run_code) m_run_len++;
                else begin
                    m_run_code = code;
                    m_run_len = 1;
                end
                if (m_run_len >= DEB) begin
                    m_flag = 1; m_key = code; m_held = 1;
                    m_gap = 0; m_rep = 0; m_run_len = 0;
                end
            end else begin
                m_run_len = 0;
            end
        end else if (n == 0) begin
            m_gap++;
            m_rep = 0;
            if (m_gap >= DEB) begin
                m_held = 0;
                m_gap = 0;
            end
        end else if (m_gap > 0) begin
            m_gap = 0;
            m_rep = 0;
        end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
            if (n == 1 && code == m_key) begin
                m_rep++;
                if (m_rep == REP) begin
                    m_flag = 1;
                    m_rep = 0;
                end
            end else begin
                m_rep = 0;
            end
`endif
        end
    endtask

    // Plays one complete scan with pattern p, checking every cycle against the
    // model state left by the previous scan.
    task automatic run_scan(input logic [15:0] p, input string tag);
        logic       exp_flag;
        logic [3:0] exp_row;
        keys_down = p;
        for (int c = 0; c < WIN; c++) begin
            @(posedge clk);
            #1;
            exp_flag = (c == 0) ? m_flag : 1'b0;
            exp_row  = ~(4'b0001 << (((c + 1) / SCAN_DIV) % 4));
            if (flag === 1'b1) flag_total++;
            checks++;
            if (flag !== exp_flag) begin
                errors++;
                $display("FAIL %s flag cyc %0d: got %b expected %b", tag, c, flag, exp_flag);
            end
            checks++;
            if (key !== 4'(m_key)) begin
                errors++;
                $display("FAIL %s key cyc %0d: got %0d expected %0d", tag, c, key, m_key);
            end
            checks++;
            if (pressed !== m_held) begin
                errors++;
                $display("FAIL %s pressed cyc %0d: got %b expected %b", tag, c, pressed, m_held);
            end
            checks++;
            if (row !== exp_row) begin
                errors++;
                $display("FAIL %s row cyc %0d: got %b expected %b", tag, c, row, exp_row);
            end
        end
        model_scan(p);
    endtask

    task automatic run_n(input logic [15:0] p, input int n, input string tag);
        for (int i = 0; i < n; i++) run_scan(p, tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (row !== 4'b1110 || key !== 4'd0 || flag !== 1'b0 || pressed !== 1'b0) begin
            errors++;
            $display("FAIL %s: got row=%b key=%0d flag=%b pressed=%b expected row=1110 key=0 flag=0 pressed=0",
                     tag, row, key, flag, pressed);
        end
    endtask

    task automatic check_count(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Asserts reset a few ns after a clock edge, checks outputs immediately,
    // then releases on a falling edge so the next scan starts aligned.
    task automatic do_reset(input string tag);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_reset_outputs(tag);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        model_reset();
        #1;
        check_reset_outputs("reset_at_start");
        @(negedge clk);
        rst = 1'b1;
        run_n(16'h0000, 4, "idle");
    endtask

    task automatic test_single_press();
        int base;
        base = flag_total;
        run_n(16'h0200, 24, "single_press");
        check_count("single_press flag count", flag_total - base, 1);
        check_count("single_press key", int'(key), 9);
        check_count("single_press pressed", int'(pressed), 1);
    endtask

    task automatic test_bounce();
        int base;
        run_n(16'h0000, 4, "bounce_release");
        base = flag_total;
        run_scan(16'h0200, "bounce");
        run_scan(16'h0000, "bounce");
        run_scan(16'h0200, "bounce");
        run_scan(16'h0000, "bounce");
        run_n(16'h0200, 5, "bounce_stable");
        check_count("bounce flag count", flag_total - base, 1);
        check_count("bounce key", int'(key), 9);
    endtask

    task automatic test_multi();
        int base;
        run_n(16'h0000, 4, "multi_release");
        base = flag_total;
        run_n(16'h0021, 10, "multi");
        run_scan(16'h0000, "multi_end");
        check_count("multi flag count", flag_total - base, 0);
        check_count("multi key kept", int'(key), 9);
    endtask

    task automatic test_release_repress();
        int base;
        run_n(16'h0200, 4, "repress_first");
        base = flag_total;
        run_scan(16'h0000, "short_release");
        run_n(16'h0200, 3, "short_repress");
        check_count("short release flag count", flag_total - base, 0);
        run_n(16'h0000, 3, "long_release");
        run_n(16'h0200, 4, "long_repress");
        check_count("long release flag count", flag_total - base, 1);
        check_count("long release key", int'(key), 9);
    endtask

    task automatic test_reset_mid_held();
        run_n(16'h0000, 4, "midheld_release");
        run_n(16'h0400, 3, "midheld_press");
        // the accepting flag is high right after the next edge; reset lands on it
        do_reset("reset_mid_held");
        run_n(16'h0000, 2, "after_reset");
    endtask

    task automatic test_random();
        logic [15:0] p;
        int kind;
        int a;
        int b;
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 3);
            a = $urandom_range(0, 15);
            b = (a + $urandom_range(1, 15)) % 16;
            case (kind)
                0: p = 16'h0000;
                1, 2: p = 16'h0001 << a;
                default: p = (16'h0001 << a) | (16'h0001 << b);
            endcase
            run_n(p, $urandom_range(1, 6), "random");
        end
        run_n(16'h0000, 4, "random_tail");
    endtask

`ifdef KEYPAD_AUTOREPEAT_EN
    task automatic test_autorepeat();
        int base;
        base = flag_total;
        run_n(16'h8000, 28, "autorepeat");
        check_count("autorepeat flag count", flag_total - base, 4);
        check_count("autorepeat key", int'(key), 15);
        run_n(16'h0000, 4, "autorepeat_release");
    endtask
`endif

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_multi();
        test_release_repress();
        test_reset_mid_held();
        test_random();
`ifdef KEYPAD_AUTOREPEAT_EN
        test_autorepeat();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans the 4x4 matrix keypad, debounces presses and delivers one clean key event per physical press to the encoder input register. It is the stage directly upstream of `encoder_controller`: `key` feeds its `key` input and `flag` feeds its `flag` input, and each press appends exactly one symbol. Row drive, column synchronisation, single-key validation and press/release debouncing are all handled here, so the register never sees bounce or ghost keys.

## Interface
- `SCAN_DIV`, 50000: clock cycles each row is driven; must be ≥ 4.
- `DEBOUNCE_SCANS`, 4: consecutive identical full scans required to accept a press or a release; must be ≥ 1.
- `REPEAT_SCANS`, 32: full scans between auto-repeat events; used only when `KEYPAD_AUTOREPEAT_EN` is defined.
- `clk  input  1`: system clock.
- `rst  input  1`: asynchronous, active-low reset.
- `col  input  4`: keypad columns, active-low, pulled up on the board.
- `row  output  4`: keypad rows, one-hot active-low drive.
- `key  output  4`: code of the last accepted key, `4*row_index + col_index`.
- `flag  output  1`: one-cycle pulse per accepted key event.
- `pressed  output  1`: high while a key is accepted and held (states HELD and RELEASE).

## Operation
- `col` passes through a 2-flop synchroniser; all logic uses the synchronised value.
- Row counter r (0..3) advances every `SCAN_DIV` cycles: `row = ~(1<<r)`, wrapping 3→0.
- Columns are sampled on the last cycle of each row dwell into a 16-bit snapshot, bit `4*r+c`.
- A scan is complete at the row-3 sample. A complete scan is classified as NONE (0 bits), SINGLE(code) (exactly 1 bit) or MULTI (≥2 bits).
- State machine, evaluated once per complete scan:
  - IDLE: on SINGLE(k), load candidate k, set cnt=1 and go to DEBOUNCE. Stay in IDLE on NONE or MULTI.
  - DEBOUNCE: on SINGLE(k) equal to candidate, increment cnt. When cnt reaches `DEBOUNCE_SCANS`, set `key`=k, pulse `flag` and go to HELD. On SINGLE of a different code, reload the candidate with cnt=1. On NONE or MULTI, go to IDLE.
  - HELD: on NONE, set cnt=1 and go to RELEASE. On SINGLE or MULTI, stay.
  - RELEASE: on NONE, increment cnt; reaching `DEBOUNCE_SCANS` goes to IDLE. Any non-NONE scan returns to HELD with no new flag.
- With `DEBOUNCE_SCANS`=1, the press is accepted directly from IDLE on the first SINGLE scan.
- `key` holds its value until the next accepted event. It never changes on MULTI, release or bounce.
- The counter saturates and never wraps.

## Timing
- Reset values: `row`=4'b1110, `key`=0, `flag`=0, `pressed`=0, state IDLE, r=0, all counters 0, snapshot 0, synchroniser 4'b1111.
- Reset is asynchronous: every output takes its reset value immediately, including mid-scan or mid-HELD.
- Full scan period is `4*SCAN_DIV` cycles.
- `flag` and the `key` update occur on the clock edge after the completing row-3 sample. `key` is valid in the same cycle `flag` is high.
- Column-to-sample latency is 2 cycles from the synchroniser plus the remaining dwell time.
- Minimum stable press to `flag` is `DEBOUNCE_SCANS` complete scans.
- `flag` is never high for two consecutive cycles.

## Configuration
- `KEYPAD_AUTOREPEAT_EN` defined: in HELD, a repeat counter increments on each SINGLE scan of the held key. At `REPEAT_SCANS` it re-pulses `flag` with the same `key` and clears. Entry to HELD, and any MULTI or NONE scan, clears the counter.
- `KEYPAD_AUTOREPEAT_EN` not defined: no repeat logic. Exactly one `flag` per press/release cycle.

## Test plan
Use `SCAN_DIV`=4, `DEBOUNCE_SCANS`=3 and a bench keypad model.
- Reset, no keys: `row` cycles 1110→1101→1011→0111 every 4 cycles. `key`=0, `flag`=0, `pressed`=0 throughout.
- Hold row 2 / col 1 steady: a single 1-cycle `flag` with `key`=9 appears after 3 complete scans and `pressed`=1. No further `flag` for 20 scans.
- Bounce: the press toggles over 2 scans, then stays stable. Exactly one `flag`, with `key`=9.
- Keys 0 and 5 held together for 10 scans: no `flag`, `key` keeps its previous value.
- Release key 9 for 1 scan, then re-press: no flag. Release for 3 scans, then re-press: a second `flag` with `key`=9. Drop `rst` low mid-HELD: all outputs reset asynchronously.
- With `KEYPAD_AUTOREPEAT_EN` defined and `REPEAT_SCANS`=8, hold key 15: `flag` pulses at acceptance, then every 8 scans with `key`=15.
